// File: rtl/wb_write_scheduler_if.sv
// Bundles the MEM/WB writeback requests, register-file write port and operand lookups
// that pass between the pipeline and the writeback scheduler.
interface wb_write_scheduler_if #(
    parameter int XLEN = 32
);
    logic            wb_valid_0;
    logic [4:0]      wb_rd_0;
    logic [XLEN-1:0] wb_data_0;
    logic            wb_valid_1;
    logic [4:0]      wb_rd_1;
    logic [XLEN-1:0] wb_data_1;
    logic            wb_stall;

    logic            rf_we;
    logic [4:0]      rf_waddr;
    logic [XLEN-1:0] rf_wdata;

    logic [4:0]      q_rs_a;
    logic            q_hit_a;
    logic [XLEN-1:0] q_data_a;
    logic [4:0]      q_rs_b;
    logic            q_hit_b;
    logic [XLEN-1:0] q_data_b;

    // Pipeline side: issues writeback requests and operand lookups.
    modport master (
        output wb_valid_0, wb_rd_0, wb_data_0,
        output wb_valid_1, wb_rd_1, wb_data_1,
        output q_rs_a, q_rs_b,
        input  wb_stall,
        input  rf_we, rf_waddr, rf_wdata,
        input  q_hit_a, q_data_a, q_hit_b, q_data_b
    );

    // Scheduler side.
    modport slave (
        input  wb_valid_0, wb_rd_0, wb_data_0,
        input  wb_valid_1, wb_rd_1, wb_data_1,
        input  q_rs_a, q_rs_b,
        output wb_stall,
        output rf_we, rf_waddr, rf_wdata,
        output q_hit_a, q_data_a, q_hit_b, q_data_b
    );
endinterface

// File: rtl/wb_write_scheduler.sv
// Serialises the two writeback lanes onto the single register-file write port through a
// small in-order FIFO, with pending-write lookup and back-pressure when nearly full.
module wb_write_scheduler #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    wb_write_scheduler_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] STALL_LEVEL = CNT_W'(DEPTH - 1);

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;

    logic [4:0]      rd_mem   [DEPTH];
    logic [XLEN-1:0] data_mem [DEPTH];

    logic             stall;
    logic             draining;
    logic             enq_0;
    logic             enq_1;
    logic [1:0]       n_enq;
    logic [PTR_W-1:0] slot_1;

    // Lane 0 is dropped when the younger lane 1 targets the same register this cycle.
    always_comb begin
        stall      = (count >= STALL_LEVEL);
        draining   = (count != '0);
        enq_1      = !stall && bus.wb_valid_1 && (bus.wb_rd_1 != 5'd0);
        enq_0      = !stall && bus.wb_valid_0 && (bus.wb_rd_0 != 5'd0)
                     && !(bus.wb_valid_1 && (bus.wb_rd_1 == bus.wb_rd_0));
        n_enq      = {1'b0, enq_0} + {1'b0, enq_1};
        slot_1     = enq_0 ? (tail + PTR_W'(1)) : tail;
        count_next = count + CNT_W'(n_enq) - CNT_W'(draining);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                rd_mem[i]   <= '0;
                data_mem[i] <= '0;
            end
        end else begin
            if (enq_0) begin
                rd_mem[tail]   <= bus.wb_rd_0;
                data_mem[tail] <= bus.wb_data_0;
            end
            if (enq_1) begin
                rd_mem[slot_1]   <= bus.wb_rd_1;
                data_mem[slot_1] <= bus.wb_data_1;
            end
            tail <= tail + PTR_W'(n_enq);
            if (draining) begin
                head <= head + PTR_W'(1);
            end
            count <= count_next;
        end
    end

    // Scans occupied slots oldest to youngest so the youngest match is the one kept.
    function automatic logic [XLEN:0] lookup(input logic [4:0] rs);
        logic [XLEN:0]    result;
        logic [PTR_W-1:0] idx;
        result = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PTR_W'(i);
            if ((CNT_W'(i) < count) && (rs != 5'd0) && (rd_mem[idx] == rs)) begin
                result = {1'b1, data_mem[idx]};
            end
        end
        return result;
    endfunction

    logic [XLEN:0] look_a;
    logic [XLEN:0] look_b;

    always_comb begin
        look_a       = lookup(bus.q_rs_a);
        look_b       = lookup(bus.q_rs_b);
        bus.q_hit_a  = look_a[XLEN];
        bus.q_data_a = look_a[XLEN-1:0];
        bus.q_hit_b  = look_b[XLEN];
        bus.q_data_b = look_b[XLEN-1:0];
    end

    always_comb begin
        bus.wb_stall = stall;
        bus.rf_we    = draining;
        bus.rf_waddr = draining ? rd_mem[head]   : 5'd0;
        bus.rf_wdata = draining ? data_mem[head] : '0;
    end
endmodule

// File: tb/tb_wb_write_scheduler.sv
// Randomised scoreboard bench for wb_write_scheduler against a queue-based model of the
// pending-write buffer.
module tb_wb_write_scheduler;
    localparam int DEPTH = 4;
    localparam int XLEN  = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    wb_write_scheduler_if #(.XLEN(XLEN)) bus();

    wb_write_scheduler #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } wr_t;

    wr_t exp_q[$];
    wr_t model_q[$];
    int  errors = 0;
    int  checks = 0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Program-order list of the writes one request cycle should produce.
    function automatic void filterReq(input logic v0, input logic [4:0] rd0, input logic [XLEN-1:0] d0,
                                      input logic v1, input logic [4:0] rd1, input logic [XLEN-1:0] d1,
                                      output int n, output wr_t a, output wr_t b);
        wr_t l0, l1;
        l0 = '{rd: rd0, data: d0};
        l1 = '{rd: rd1, data: d1};
        n = 0;
        a = '0;
        b = '0;
        if (v0 && rd0 != 5'd0 && !(v1 && rd1 == rd0)) begin
            a = l0;
            n = 1;
        end
        if (v1 && rd1 != 5'd0) begin
            if (n == 0) a = l1;
            else        b = l1;
            n++;
        end
    endfunction

    function automatic bit modelStall();
        return (DEPTH - model_q.size()) < 2;
    endfunction

    function automatic void modelLookup(input logic [4:0] rs, output logic hit, output logic [XLEN-1:0] data);
        hit  = 1'b0;
        data = '0;
        foreach (model_q[i]) begin
            if (rs != 5'd0 && model_q[i].rd == rs) begin
                hit  = 1'b1;
                data = model_q[i].data;
            end
        end
    endfunction

    // Buffer model: one drain per edge when non-empty, then accepted requests append.
    always @(posedge clk or negedge rst_n) begin
        int  n;
        wr_t a, b;
        bit  st;
        if (!rst_n) begin
            model_q.delete();
        end else begin
            st = modelStall();
            if (model_q.size() != 0) void'(model_q.pop_front());
            if (!st) begin
                filterReq(bus.wb_valid_0, bus.wb_rd_0, bus.wb_data_0,
                          bus.wb_valid_1, bus.wb_rd_1, bus.wb_data_1, n, a, b);
                if (n >= 1) model_q.push_back(a);
                if (n == 2) model_q.push_back(b);
            end
        end
    end

    // Monitor: consumes the scoreboard whenever the DUT writes the register file.
    always @(negedge clk) begin
        wr_t             e;
        logic            h;
        logic [XLEN-1:0] d;
        if (rst_n) begin
            checkOutput("rf_we", 64'(bus.rf_we), 64'(model_q.size() != 0));
            if (bus.rf_we === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checkOutput("rf_write_unexpected", 64'(1), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("rf_waddr", 64'(bus.rf_waddr), 64'(e.rd));
                    checkOutput("rf_wdata", 64'(bus.rf_wdata), 64'(e.data));
                end
            end
            checkOutput("wb_stall", 64'(bus.wb_stall), 64'(modelStall()));
            modelLookup(bus.q_rs_a, h, d);
            checkOutput("q_hit_a", 64'(bus.q_hit_a), 64'(h));
            checkOutput("q_data_a", 64'(bus.q_data_a), 64'(d));
            modelLookup(bus.q_rs_b, h, d);
            checkOutput("q_hit_b", 64'(bus.q_hit_b), 64'(h));
            checkOutput("q_data_b", 64'(bus.q_data_b), 64'(d));
        end
    end

    // Issues one request cycle, holding it while the buffer reports stall.
    task automatic applyStimulus(input logic v0, input logic [4:0] rd0, input logic [XLEN-1:0] d0,
                                 input logic v1, input logic [4:0] rd1, input logic [XLEN-1:0] d1,
                                 input logic [4:0] qa, input logic [4:0] qb);
        int  waited = 0;
        int  n;
        wr_t a, b;
        @(posedge clk);
        #1;
        bus.q_rs_a = qa;
        bus.q_rs_b = qb;
        while (modelStall() && (v0 || v1)) begin
            bus.wb_valid_0 = 1'b0;
            bus.wb_valid_1 = 1'b0;
            waited++;
            if (waited > 50) begin
                checkOutput("stall_timeout", 64'(1), 64'(0));
                return;
            end
            @(posedge clk);
            #1;
        end
        bus.wb_valid_0 = v0;
        bus.wb_rd_0    = rd0;
        bus.wb_data_0  = d0;
        bus.wb_valid_1 = v1;
        bus.wb_rd_1    = rd1;
        bus.wb_data_1  = d1;
        filterReq(v0, rd0, d0, v1, rd1, d1, n, a, b);
        if (n >= 1) exp_q.push_back(a);
        if (n == 2) exp_q.push_back(b);
    endtask

    task automatic idleCycles(input int n);
        repeat (n) applyStimulus(1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 5'd0, 5'd0);
    endtask

    task automatic checkZeroOutputs(input string tag);
        checkOutput({tag, "_rf_we"},    64'(bus.rf_we),    64'(0));
        checkOutput({tag, "_rf_waddr"}, 64'(bus.rf_waddr), 64'(0));
        checkOutput({tag, "_rf_wdata"}, 64'(bus.rf_wdata), 64'(0));
        checkOutput({tag, "_wb_stall"}, 64'(bus.wb_stall), 64'(0));
        checkOutput({tag, "_q_hit_a"},  64'(bus.q_hit_a),  64'(0));
        checkOutput({tag, "_q_data_a"}, 64'(bus.q_data_a), 64'(0));
        checkOutput({tag, "_q_hit_b"},  64'(bus.q_hit_b),  64'(0));
        checkOutput({tag, "_q_data_b"}, 64'(bus.q_data_b), 64'(0));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.wb_valid_0 = 1'b0;
        bus.wb_rd_0    = '0;
        bus.wb_data_0  = '0;
        bus.wb_valid_1 = 1'b0;
        bus.wb_rd_1    = '0;
        bus.wb_data_1  = '0;
        bus.q_rs_a     = '0;
        bus.q_rs_b     = '0;

        #1 rst_n = 1'b0;
        #2 checkZeroOutputs("reset");
        #10 rst_n = 1'b1;
        $display("[TB] reset released, idle phase");
        idleCycles(10);

        $display("[TB] dual issue");
        applyStimulus(1'b1, 5'd5, 32'h11, 1'b1, 5'd6, 32'h22, 5'd5, 5'd6);
        idleCycles(4);

        $display("[TB] same-rd collision and rd==0");
        applyStimulus(1'b1, 5'd7, 32'hAA, 1'b1, 5'd7, 32'hBB, 5'd7, 5'd0);
        applyStimulus(1'b1, 5'd0, 32'h55, 1'b1, 5'd8, 32'h88, 5'd8, 5'd0);
        applyStimulus(1'b1, 5'd3, 32'h33, 1'b1, 5'd0, 32'h99, 5'd3, 5'd0);
        idleCycles(4);

        $display("[TB] fill to stall");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 5'(10 + 2 * i), 32'h100 + 32'(i), 1'b1, 5'(11 + 2 * i), 32'h200 + 32'(i),
                          5'(10 + i), 5'(11 + i));
        end
        idleCycles(8);

        $display("[TB] lookup youngest match");
        applyStimulus(1'b1, 5'd4, 32'h44, 1'b1, 5'd9, 32'h1, 5'd9, 5'd0);
        applyStimulus(1'b1, 5'd9, 32'h2, 1'b0, 5'd0, '0, 5'd9, 5'd0);
        applyStimulus(1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 5'd9, 5'd0);
        @(negedge clk);
        checkOutput("lookup_hit_a", 64'(bus.q_hit_a), 64'(1));
        checkOutput("lookup_data_a", 64'(bus.q_data_a), 64'(2));
        checkOutput("lookup_hit_b", 64'(bus.q_hit_b), 64'(0));
        idleCycles(6);

        $display("[TB] async reset with pending entries");
        applyStimulus(1'b1, 5'd12, 32'hC0, 1'b1, 5'd13, 32'hD0, 5'd12, 5'd13);
        applyStimulus(1'b1, 5'd14, 32'hE0, 1'b1, 5'd15, 32'hF0, 5'd12, 5'd14);
        @(posedge clk);
        #1;
        bus.wb_valid_0 = 1'b0;
        bus.wb_valid_1 = 1'b0;
        checkOutput("pre_reset_pending", 64'(model_q.size()), 64'(3));
        #2 rst_n = 1'b0;
        #1 checkZeroOutputs("midreset");
        exp_q.delete();
        model_q.delete();
        #10 rst_n = 1'b1;
        idleCycles(10);

        $display("[TB] random phase");
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), XLEN'($urandom),
                          1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), XLEN'($urandom),
                          5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        end
        idleCycles(8);
        checkOutput("drain_empty", 64'(exp_q.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
